// File: rtl/corr_acc_pkg.sv
// Shared definitions for the correlator accumulator bank: saturation bounds
// and the encoding of the dump buffer state.
package corr_acc_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    function automatic int sat_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/corr_acc_bank_if.sv
// Sample, context-restore, dump-drain and status signals of one correlator channel.
// master drives samples and commands; slave is the accumulator bank.
interface corr_acc_bank_if #(
    parameter int ACC_DATA_WIDTH = 16,
    parameter int IN_WIDTH       = 6,
    parameter int NUM_CORR       = 3,
    parameter int CNT_WIDTH      = 10
);
    localparam int VW = NUM_CORR * ACC_DATA_WIDTH;

    logic                 acc_load;
    logic [VW-1:0]        i_acc_i;
    logic [VW-1:0]        q_acc_i;
    logic [CNT_WIDTH-1:0] cnt_i;
    logic                 sample_valid;
    logic [IN_WIDTH-1:0]  i_data_pos;
    logic [IN_WIDTH-1:0]  q_data_pos;
    logic [IN_WIDTH-1:0]  i_data_neg;
    logic [IN_WIDTH-1:0]  q_data_neg;
    logic [NUM_CORR-1:0]  prn_code;
    logic [CNT_WIDTH-1:0] dump_len;
    logic                 dump_ready;
    logic                 status_clear;
    logic [VW-1:0]        i_acc_o;
    logic [VW-1:0]        q_acc_o;
    logic [CNT_WIDTH-1:0] cnt_o;
    logic                 dump_valid;
    logic [VW-1:0]        i_dump_o;
    logic [VW-1:0]        q_dump_o;
    logic                 sat_flag;
    logic                 overrun_flag;

    modport master (
        output acc_load, i_acc_i, q_acc_i, cnt_i, sample_valid,
               i_data_pos, q_data_pos, i_data_neg, q_data_neg, prn_code,
               dump_len, dump_ready, status_clear,
        input  i_acc_o, q_acc_o, cnt_o, dump_valid, i_dump_o, q_dump_o,
               sat_flag, overrun_flag
    );

    modport slave (
        input  acc_load, i_acc_i, q_acc_i, cnt_i, sample_valid,
               i_data_pos, q_data_pos, i_data_neg, q_data_neg, prn_code,
               dump_len, dump_ready, status_clear,
        output i_acc_o, q_acc_o, cnt_o, dump_valid, i_dump_o, q_dump_o,
               sat_flag, overrun_flag
    );

endinterface

// File: rtl/corr_acc_tap.sv
// One I/Q correlator tap: chip-selected sample, sign extension and saturating add.
// Purely combinational; the bank registers the result.
module corr_acc_tap
    import corr_acc_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = 16,
    parameter int IN_WIDTH       = 6
) (
    input  logic [IN_WIDTH-1:0]       i_pos,
    input  logic [IN_WIDTH-1:0]       i_neg,
    input  logic [IN_WIDTH-1:0]       q_pos,
    input  logic [IN_WIDTH-1:0]       q_neg,
    input  logic                      chip,
    input  logic [ACC_DATA_WIDTH-1:0] i_acc,
    input  logic [ACC_DATA_WIDTH-1:0] q_acc,
    output logic [ACC_DATA_WIDTH-1:0] i_sum,
    output logic [ACC_DATA_WIDTH-1:0] q_sum,
    output logic                      sat
);
    localparam int W    = ACC_DATA_WIDTH;
    localparam int SMAX = sat_max(W);
    localparam int SMIN = sat_min(W);
    localparam logic [W-1:0] MAX_V = SMAX[W-1:0];
    localparam logic [W-1:0] MIN_V = SMIN[W-1:0];

    // One guard bit is enough: |sample| is far below the accumulator range.
    function automatic logic [W:0] add_ext(input logic [W-1:0] acc, input logic [IN_WIDTH-1:0] x);
        return {acc[W-1], acc} + {{(W + 1 - IN_WIDTH){x[IN_WIDTH-1]}}, x};
    endfunction

    logic [W:0] i_raw;
    logic [W:0] q_raw;
    logic       i_ovf;
    logic       q_ovf;

    assign i_raw = add_ext(i_acc, chip ? i_neg : i_pos);
    assign q_raw = add_ext(q_acc, chip ? q_neg : q_pos);
    assign i_ovf = i_raw[W] ^ i_raw[W-1];
    assign q_ovf = q_raw[W] ^ q_raw[W-1];

    assign i_sum = !i_ovf ? i_raw[W-1:0] : (i_raw[W] ? MIN_V : MAX_V);
    assign q_sum = !q_ovf ? q_raw[W-1:0] : (q_raw[W] ? MIN_V : MAX_V);
    assign sat   = i_ovf | q_ovf;

endmodule

// File: rtl/corr_acc_bank.sv
// Multi-tap coherent accumulator for one time-multiplexed correlator channel,
// with period counter, dump buffer handshake, sticky flags and context restore.
module corr_acc_bank
    import corr_acc_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = 16,
    parameter int IN_WIDTH       = 6,
    parameter int NUM_CORR       = 3,
    parameter int CNT_WIDTH      = 10
) (
    input  logic            clk,
    input  logic            rst_b,
    corr_acc_bank_if.slave  bus
);
    localparam int W = ACC_DATA_WIDTH;

    logic [W-1:0]          i_acc_reg  [NUM_CORR];
    logic [W-1:0]          q_acc_reg  [NUM_CORR];
    logic [W-1:0]          i_dump_reg [NUM_CORR];
    logic [W-1:0]          q_dump_reg [NUM_CORR];
    logic [W-1:0]          i_sum      [NUM_CORR];
    logic [W-1:0]          q_sum      [NUM_CORR];
    logic [NUM_CORR-1:0]   tap_sat;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    buf_state_t            buf_reg;
    buf_state_t            buf_next;
    logic                  sat_reg;
    logic                  sat_next;
    logic                  ovr_reg;
    logic                  ovr_next;
    logic                  accumulate;
    logic                  dump_event;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORR; gi++) begin : g_tap
            corr_acc_tap #(
                .ACC_DATA_WIDTH (ACC_DATA_WIDTH),
                .IN_WIDTH       (IN_WIDTH)
            ) u_tap (
                .i_pos (bus.i_data_pos),
                .i_neg (bus.i_data_neg),
                .q_pos (bus.q_data_pos),
                .q_neg (bus.q_data_neg),
                .chip  (bus.prn_code[gi]),
                .i_acc (i_acc_reg[gi]),
                .q_acc (q_acc_reg[gi]),
                .i_sum (i_sum[gi]),
                .q_sum (q_sum[gi]),
                .sat   (tap_sat[gi])
            );
            assign bus.i_acc_o[gi*W +: W]  = i_acc_reg[gi];
            assign bus.q_acc_o[gi*W +: W]  = q_acc_reg[gi];
            assign bus.i_dump_o[gi*W +: W] = i_dump_reg[gi];
            assign bus.q_dump_o[gi*W +: W] = q_dump_reg[gi];
        end
    endgenerate

    assign accumulate = bus.sample_valid & ~bus.acc_load;
    // ">=" also catches a counter left beyond a freshly shortened period.
    assign dump_event = accumulate && (bus.dump_len != '0) &&
                        (cnt_reg >= bus.dump_len - CNT_WIDTH'(1));

    always_comb begin
        buf_next = buf_reg;
        if (dump_event)
            buf_next = BUF_FULL;
        else if (bus.dump_ready)
            buf_next = BUF_EMPTY;
        sat_next = (accumulate & (|tap_sat)) | (sat_reg & ~bus.status_clear);
        ovr_next = (dump_event & (buf_reg == BUF_FULL) & ~bus.dump_ready) |
                   (ovr_reg & ~bus.status_clear);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < NUM_CORR; k++) begin
                i_acc_reg[k]  <= '0;
                q_acc_reg[k]  <= '0;
                i_dump_reg[k] <= '0;
                q_dump_reg[k] <= '0;
            end
            cnt_reg <= '0;
            buf_reg <= BUF_EMPTY;
            sat_reg <= 1'b0;
            ovr_reg <= 1'b0;
        end else begin
            if (bus.acc_load) begin
                for (int k = 0; k < NUM_CORR; k++) begin
                    i_acc_reg[k] <= bus.i_acc_i[k*W +: W];
                    q_acc_reg[k] <= bus.q_acc_i[k*W +: W];
                end
                cnt_reg <= bus.cnt_i;
            end else if (accumulate) begin
                if (dump_event) begin
                    for (int k = 0; k < NUM_CORR; k++) begin
                        i_dump_reg[k] <= i_sum[k];
                        q_dump_reg[k] <= q_sum[k];
                        i_acc_reg[k]  <= '0;
                        q_acc_reg[k]  <= '0;
                    end
                    cnt_reg <= '0;
                end else begin
                    for (int k = 0; k < NUM_CORR; k++) begin
                        i_acc_reg[k] <= i_sum[k];
                        q_acc_reg[k] <= q_sum[k];
                    end
                    if (bus.dump_len != '0)
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end
            buf_reg <= buf_next;
            sat_reg <= sat_next;
            ovr_reg <= ovr_next;
        end
    end

    assign bus.cnt_o        = cnt_reg;
    assign bus.dump_valid   = (buf_reg == BUF_FULL);
    assign bus.sat_flag     = sat_reg;
    assign bus.overrun_flag = ovr_reg;

endmodule

// File: doc/corr_acc_bank.md
Name: corr_acc_bank

Overview:
- Multi-tap coherent accumulator for one time-multiplexed correlator channel, for example early/prompt/late taps.
- Each tap selects the pre-mixed positive or negative sample by its own PRN chip, then accumulates it with saturation.
- Coherent length is counted internally. At the end of each period the block dumps all taps into a result buffer that is drained with a valid/ready handshake.
- Accumulator and count state can be saved and restored, so channels can be context-switched.

Parameters:
- ACC_DATA_WIDTH, 16, accumulator width per I/Q per tap (two's complement).
- IN_WIDTH, 6, width of the mixed input samples (two's complement).
- NUM_CORR, 3, number of taps.
- CNT_WIDTH, 10, width of the coherent sample counter and of dump_len.

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- acc_load  in  1  load accumulators and counter from the *_i buses
- i_acc_i  in  NUM_CORR*ACC_DATA_WIDTH  I accumulator restore values; tap k occupies [k*W +: W]
- q_acc_i  in  NUM_CORR*ACC_DATA_WIDTH  Q accumulator restore values
- cnt_i  in  CNT_WIDTH  counter restore value
- sample_valid  in  1  accumulate the current sample
- i_data_pos  in  IN_WIDTH  I sample, code +1
- q_data_pos  in  IN_WIDTH  Q sample, code +1
- i_data_neg  in  IN_WIDTH  I sample, code -1
- q_data_neg  in  IN_WIDTH  Q sample, code -1
- prn_code  in  NUM_CORR  per-tap code chip; 1 selects the *_neg sample
- dump_len  in  CNT_WIDTH  samples per coherent period; 0 disables dumping
- dump_ready  in  1  consumer accepts the dump buffer
- status_clear  in  1  clears the sticky flags
- i_acc_o  out  NUM_CORR*ACC_DATA_WIDTH  live I accumulators, for save
- q_acc_o  out  NUM_CORR*ACC_DATA_WIDTH  live Q accumulators, for save
- cnt_o  out  CNT_WIDTH  live sample counter
- dump_valid  out  1  dump buffer holds unread data
- i_dump_o  out  NUM_CORR*ACC_DATA_WIDTH  dumped I results
- q_dump_o  out  NUM_CORR*ACC_DATA_WIDTH  dumped Q results
- sat_flag  out  1  sticky: some accumulator saturated
- overrun_flag  out  1  sticky: an unread dump was overwritten

Behaviour:
- Clock and reset: single clock clk. Reset rst_b is asynchronous, active-low. Reset clears every output and all internal registers to 0.
- Priority, per cycle: acc_load wins over sample_valid.
  - acc_load=1: i/q_acc_o and cnt_o take the *_i values next cycle; the dump buffer and flags are untouched.
  - Neither acc_load nor sample_valid: state holds.
- Accumulate (sample_valid=1, acc_load=0), for each tap k:
  - Select x = prn_code[k] ? *_neg : *_pos.
  - Sign-extend x to ACC_DATA_WIDTH+1 bits and add the current accumulator value.
  - Clamp the sum to [-2^(W-1), 2^(W-1)-1]. Any clamp sets sat_flag.
  - Result is registered with 1-cycle latency.
- Counter:
  - dump_len=0: cnt_o holds and no dump ever occurs.
  - Otherwise, on each accumulate: if cnt_o == dump_len-1, a dump event occurs; else cnt_o increments.
  - If cnt_o >= dump_len (e.g. dump_len reduced mid-period), the same cycle is also a dump event.
- Dump event:
  - The saturated sums, including the current sample, go to i/q_dump_o.
  - The live accumulators and cnt_o go to 0.
  - dump_valid rises next cycle.
- Dump buffer, two states: EMPTY (dump_valid=0) and FULL (dump_valid=1).
  - FULL and dump_ready=1 with no dump event: go to EMPTY.
  - Dump event in EMPTY: go to FULL.
  - Dump event in FULL with dump_ready=1: new data loaded, stays FULL, no overrun.
  - Dump event in FULL with dump_ready=0: data overwritten, overrun_flag set.
  - dump_ready while EMPTY: ignored.
- Flags: status_clear clears sat_flag and overrun_flag. If a set and status_clear occur in the same cycle, set wins.
- Outputs are registers only, with no combinational input-to-output paths.
- Widths: ACC_DATA_WIDTH > IN_WIDTH is required.

Decomposition:
- Package corr_acc_pkg holds:
  - the saturation bounds functions, sat_max(W) and sat_min(W);
  - the buffer state encoding, BUF_EMPTY and BUF_FULL.
- One sub-module, corr_acc_tap: a single I/Q tap covering select, sign-extend and saturating add. It is instantiated NUM_CORR times in a generate loop.
- The counter, dump control and flags stay in the top level.

Test Plan:
- Basic dump, defaults, dump_len=4: 4 samples with i_data_pos=5, i_data_neg=-5, prn_code=3'b010 -> i_dump_o taps 20, -20, 20; dump_valid=1 one cycle after the 4th sample; live accumulators=0, cnt_o=0.
- Saturation: restore I tap0=32760, then accumulate +7 twice -> i_acc_o tap0=32767 and sat_flag=1. Then status_clear -> sat_flag=0. Repeat for the negative side: restore -32765, accumulate -6 -> -32768.
- Handshake and overrun: dump_len=2, dump_ready=0 across two periods -> second data overwrites the first, overrun_flag=1. Then a dump event concurrent with dump_ready=1 -> new data, dump_valid stays 1, no new overrun.
- Context switch: acc_load with tap values 100/-50/7 and cnt_i=3, asserted together with sample_valid -> next cycle exact restored values, sample ignored.
- dump_len=0: 2000 samples -> no dump_valid, cnt_o=0, accumulators saturate correctly.
- Reset mid-operation: assert rst_b=0 while FULL and flags set -> all outputs 0 asynchronously. After release, a fresh period dumps correctly.
